// File: rtl/button_debounce_multi.sv
// Multi-channel button conditioner: 2-flop synchroniser, stability counter, press/release strobes.
// Typematic auto-repeat strobes are built only when BUTTON_DEBOUNCE_AUTOREPEAT_EN is defined.
module button_debounce_multi #(
  parameter int unsigned CHANNELS    = 5,
  parameter int unsigned NR_OF_CLKS  = 4096,
  parameter int unsigned HOLD_CLKS   = 25000000,
  parameter int unsigned REPEAT_CLKS = 5000000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_sig,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_press,
  output logic [CHANNELS-1:0] o_rel,
  output logic [CHANNELS-1:0] o_rpt,
  output logic                o_any_evt
);

  localparam int unsigned CntW = (NR_OF_CLKS > 1) ? $clog2(NR_OF_CLKS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(NR_OF_CLKS - 1);

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned HoldW  = (HOLD_CLKS > 1) ? $clog2(HOLD_CLKS) : 1;
  localparam int unsigned RepW   = (REPEAT_CLKS > 1) ? $clog2(REPEAT_CLKS) : 1;
  localparam int unsigned RcntW  = (HoldW > RepW) ? HoldW : RepW;
  localparam logic [RcntW-1:0] HoldMax = RcntW'(HOLD_CLKS - 1);
  localparam logic [RcntW-1:0] RepMax  = RcntW'(REPEAT_CLKS - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} rpt_state_e;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{HOLD_CLKS, REPEAT_CLKS};
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic            r_s1;
    logic            r_s2;
    logic            r_last;
    logic [CntW-1:0] r_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_rel;
    logic            w_level_d;

    // The level follows s2 only once it has been stable for the full count.
    always_comb begin
      w_level_d = r_level;
      if ((r_s2 == r_last) && (r_cnt == CntMax)) begin
        w_level_d = r_last;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_last  <= 1'b0;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_s1 <= i_sig[g];
        r_s2 <= r_s1;
        if (r_s2 != r_last) begin
          r_last <= r_s2;
          r_cnt  <= '0;
        end else if (r_cnt != CntMax) begin
          r_cnt <= r_cnt + 1'b1;
        end
        r_level <= w_level_d;
        r_press <= w_level_d & ~r_level;
        r_rel   <= ~w_level_d & r_level;
      end
    end

    assign o_level[g] = r_level;
    assign o_press[g] = r_press;
    assign o_rel[g]   = r_rel;

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    rpt_state_e       r_state;
    logic [RcntW-1:0] r_rcnt;
    logic             r_rpt;

    // HOLD is entered on the same edge that raises press, so the press cycle has rcnt=0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state <= StIdle;
        r_rcnt  <= '0;
        r_rpt   <= 1'b0;
      end else begin
        r_rpt <= 1'b0;
        if (!w_level_d) begin
          r_state <= StIdle;
          r_rcnt  <= '0;
        end else begin
          case (r_state)
            StIdle: begin
              if (!r_level) begin
                r_state <= StHold;
                r_rcnt  <= '0;
              end
            end
            StHold: begin
              if (r_rcnt == HoldMax) begin
                r_rpt   <= 1'b1;
                r_rcnt  <= '0;
                r_state <= StRepeat;
              end else begin
                r_rcnt <= r_rcnt + 1'b1;
              end
            end
            StRepeat: begin
              if (r_rcnt == RepMax) begin
                r_rpt  <= 1'b1;
                r_rcnt <= '0;
              end else begin
                r_rcnt <= r_rcnt + 1'b1;
              end
            end
            default: begin
              r_state <= StIdle;
              r_rcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign o_rpt[g] = r_rpt;
`else
    assign o_rpt[g] = 1'b0;
`endif
  end

  assign o_any_evt = |(o_press | o_rpt);

endmodule

// File: tb/tb_button_debounce_multi.sv
// Randomised bench for button_debounce_multi against a window/age based reference model,
// plus directed latency, bounce, multi-channel, auto-repeat and async-reset scenarios.
module tb_button_debounce_multi;

  localparam int unsigned CH = 5;
  localparam int unsigned N  = 4;
  localparam int unsigned H  = 20;
  localparam int unsigned R  = 8;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
  localparam bit AutoRpt = 1'b1;
`else
  localparam bit AutoRpt = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] sig;
  logic [CH-1:0] level;
  logic [CH-1:0] press;
  logic [CH-1:0] rel;
  logic [CH-1:0] rpt;
  logic          any_evt;

  button_debounce_multi #(
    .CHANNELS   (CH),
    .NR_OF_CLKS (N),
    .HOLD_CLKS  (H),
    .REPEAT_CLKS(R)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_sig    (sig),
    .o_level  (level),
    .o_press  (press),
    .o_rel    (rel),
    .o_rpt    (rpt),
    .o_any_evt(any_evt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: level moves to v once the last N+1 sampled synchroniser values are all v;
  // repeat strobes fall at ages H, H+R, H+2R, ... counted from the press cycle.
  logic [CH-1:0] m_s1, m_s2;
  logic [N:0]    hist [CH];
  int            age  [CH];
  logic [CH-1:0] e_level, e_press, e_rel, e_rpt;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = '0; m_s2 = '0;
        e_level = '0; e_press = '0; e_rel = '0; e_rpt = '0;
        for (int c = 0; c < CH; c++) begin
          hist[c] = '0;
          age[c]  = 0;
        end
      end else begin
        for (int c = 0; c < CH; c++) begin
          logic obs, nl;
          obs     = m_s2[c];
          m_s2[c] = m_s1[c];
          m_s1[c] = sig[c];
          hist[c] = {hist[c][N-1:0], obs};
          nl = e_level[c];
          if (&hist[c]) nl = 1'b1;
          else if (~|hist[c]) nl = 1'b0;
          e_press[c] = nl & ~e_level[c];
          e_rel[c]   = ~nl & e_level[c];
          if (e_press[c]) age[c] = 0;
          else if (nl) age[c] = age[c] + 1;
          e_rpt[c] = AutoRpt && nl && !e_press[c] && (age[c] >= H) && ((age[c] - H) % R == 0);
          e_level[c] = nl;
        end
      end
    end
  end

  bit cmp_en = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("level", 32'(level), 32'(e_level));
        check("press", 32'(press), 32'(e_press));
        check("rel", 32'(rel), 32'(e_rel));
        check("rpt", 32'(rpt), 32'(e_rpt));
        check("any_evt", 32'(any_evt), 32'(|(e_press | e_rpt)));
      end
    end
  end

  // Call right after driving sig at a negedge: returns the index of the edge that raised press.
  task automatic wait_press(input int c, output int k);
    k = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (press[c]) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    int first;
    int offs[$];
    int exp_offs[$];
    logic [CH-1:0] relv;

    rst_n = 1'b0;
    sig   = '0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({level, press, rel, rpt, any_evt}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic latency on channel 0.
    sig[0] = 1'b1;
    wait_press(0, k);
    check("latency_edge", k, 6);
    check("latency_level", 32'(level[0]), 32'd1);
    @(negedge clk);
    sig[0] = 1'b0;
    repeat (10) @(negedge clk);

    // Bounce: 3-cycle plateaus never settle.
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) sig[0] = ~sig[0];
      @(negedge clk);
      check("bounce_no_press", 32'(press[0]), 32'd0);
    end
    sig[0] = 1'b1;
    wait_press(0, k);
    check("bounce_final_edge", k, 6);
    @(negedge clk);
    sig[0] = 1'b0;
    repeat (10) @(negedge clk);

    // Multi-channel simultaneous press, release of ch3 only.
    sig = 5'b01001;
    wait_press(0, k);
    check("mc_press_vec", 32'(press), 32'(5'b01001));
    repeat (10) @(negedge clk);
    sig[3] = 1'b0;
    relv = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (rel != '0) begin
        relv = rel;
        break;
      end
    end
    check("mc_rel_vec", 32'(relv), 32'(5'b01000));
    repeat (3) @(negedge clk);
    check("mc_level_end", 32'(level), 32'(5'b00001));
    sig = '0;
    repeat (10) @(negedge clk);

    // Auto-repeat on ch1 held for 60 cycles after the press.
    sig[1] = 1'b1;
    wait_press(1, k);
    check("ar_press_edge", k, 6);
    for (int t = 1; t <= 60; t++) begin
      @(posedge clk);
      #1;
      if (rpt[1]) offs.push_back(t);
    end
    if (AutoRpt) exp_offs = '{20, 28, 36, 44, 52};
    check("ar_rpt_count", offs.size(), exp_offs.size());
    for (int i = 0; i < exp_offs.size(); i++) begin
      check("ar_rpt_offset", (i < offs.size()) ? offs[i] : -1, exp_offs[i]);
    end

    // Asynchronous reset while in the repeat phase.
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'({level, press, rel, rpt, any_evt}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_press(1, k);
    check("rst_repress_edge", k, 6);
    first = -1;
    for (int t = 1; t <= 30; t++) begin
      @(posedge clk);
      #1;
      if (rpt[1] && first < 0) first = t;
    end
    check("rst_first_rpt", first, AutoRpt ? 20 : -1);

    // Randomised phase: alternating bouncy and slow segments, occasional async reset.
    @(negedge clk);
    for (int seg = 0; seg < 20; seg++) begin
      int lim;
      lim = ($urandom_range(0, 1) == 0) ? 4 : 60;
      for (int i = 0; i < 200; i++) begin
        for (int c = 0; c < CH; c++) begin
          if ($urandom_range(0, lim) == 0) sig[c] = ~sig[c];
        end
        if ($urandom_range(0, 1499) == 0) begin
          #2;
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    sig = '0;
    repeat (20) @(negedge clk);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
